// File: rtl/copy_mux_pkg.sv
// Shared definitions for the copy_mux_pipe operand select stage.
//   - default WIDTH / NUM_SRC constants
//   - occupancy state encoding for the two-register output buffer
package copy_mux_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_NUM_SRC = 4;

  // Number of entries held in the main + skid registers.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage : copy_mux_pkg

// File: rtl/mux_n_select.sv
// Combinational N-source operand select with copy-last override.
// Ports:
//   sources      in  NUM_SRC*WIDTH  packed sources, source i at [i*WIDTH +: WIDTH]
//   sel          in  SEL_W          source index
//   hold         in  1              select last_q instead of a source
//   last_q       in  WIDTH          last accepted value
//   value        out WIDTH          selected value (zero when sel is out of range)
//   out_of_range out 1              sel >= NUM_SRC (raw, independent of hold)
module mux_n_select
  import copy_mux_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
  localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*WIDTH-1:0] sources,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     hold,
  input  logic [WIDTH-1:0]         last_q,
  output logic [WIDTH-1:0]         value,
  output logic                     out_of_range
);

  logic [WIDTH-1:0] src_val;

  // Folds to constant zero when NUM_SRC is a power of two.
  assign out_of_range = (32'(sel) >= NUM_SRC);

  // Decoded select; indices past NUM_SRC match no source and leave zero.
  always_comb begin
    src_val = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (32'(sel) == i) begin
        src_val = sources[i*WIDTH +: WIDTH];
      end
    end
  end

  // Hold has priority over the range check.
  always_comb begin
    value = src_val;
    if (hold) begin
      value = last_q;
    end else if (out_of_range) begin
      value = '0;
    end
  end

endmodule : mux_n_select

// File: rtl/copy_mux_pipe.sv
// Parametrised N-source operand select stage with registered output,
// valid/ready handshake, copy-last hold mode, sticky out-of-range flag and a
// 2-entry (main + skid) buffer so producer and consumer may stall independently.
// Ports:
//   clk        in  1              rising-edge clock
//   rst        in  1              asynchronous active-high reset
//   sources    in  NUM_SRC*WIDTH  packed sources, source i at [i*WIDTH +: WIDTH]
//   sel        in  SEL_W          source index, sampled on accept
//   hold       in  1              on accept re-issue last accepted value
//   in_valid   in  1              producer transfer request
//   in_ready   out 1              stage can accept (registered)
//   out_data   out WIDTH          head-of-buffer value (registered)
//   out_valid  out 1              out_data valid (registered)
//   out_ready  in  1              consumer takes out_data
//   sel_err    out 1              sticky: an out-of-range sel was accepted
module copy_mux_pipe
  import copy_mux_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
  localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] sources,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     hold,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err
);

  state_e           state;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] mux_val;
  logic             mux_oor;
  logic             accept;
  logic             drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Value selection ahead of the buffer.
  mux_n_select #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC)
  ) u_select (
    .sources      (sources),
    .sel          (sel),
    .hold         (hold),
    .last_q       (last_q),
    .value        (mux_val),
    .out_of_range (mux_oor)
  );

  // Buffer FSM; in_ready/out_valid are registered from the next state so
  // out_ready has no combinational path to in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      skid_q    <= '0;
      last_q    <= '0;
      sel_err   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= mux_val;
        if (!hold && mux_oor) begin
          sel_err <= 1'b1;
        end
      end

      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data  <= mux_val;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_data <= mux_val;
          end else if (accept) begin
            // Consumer stalled: park the new entry behind main.
            skid_q   <= mux_val;
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            out_data <= skid_q;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : copy_mux_pipe

// File: tb/tb_copy_mux_pipe.sv
// Scoreboard bench for copy_mux_pipe: one 4-source and one 3-source instance
// share stimulus; expected values are pushed on accept and popped on drain.
module tb_copy_mux_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src [4];
  logic [31:0] sources4;
  logic [23:0] sources3;
  logic [1:0]  sel;
  logic        hold;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready4, out_valid4, sel_err4;
  logic [7:0]  out_data4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [7:0]  out_data3;

  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state.
  logic [7:0]  q4 [$];
  logic [7:0]  q3 [$];
  logic [7:0]  last4;
  logic [7:0]  last3;
  logic        err3;
  int          occ;

  always #5 clk = ~clk;

  assign sources4 = {src[3], src[2], src[1], src[0]};
  assign sources3 = {src[2], src[1], src[0]};

  copy_mux_pipe #(.WIDTH(8), .NUM_SRC(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .sources   (sources4),
    .sel       (sel),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .sel_err   (sel_err4)
  );

  copy_mux_pipe #(.WIDTH(8), .NUM_SRC(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .sources   (sources3),
    .sel       (sel),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .sel_err   (sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q4.delete();
    q3.delete();
    last4 = 8'h00;
    last3 = 8'h00;
    err3  = 1'b0;
    occ   = 0;
  endtask

  // One clock: inputs are already driven; sample at the falling edge,
  // score drains, push accepts, then advance past the rising edge.
  task automatic cycle();
    logic       acc, drn;
    logic [7:0] e4, e3;
    @(negedge clk);
    check("in_ready4",  32'(in_ready4),  32'(occ != 2));
    check("in_ready3",  32'(in_ready3),  32'(occ != 2));
    check("out_valid4", 32'(out_valid4), 32'(occ != 0));
    check("out_valid3", 32'(out_valid3), 32'(occ != 0));
    check("sel_err4",   32'(sel_err4),   32'(0));
    check("sel_err3",   32'(sel_err3),   32'(err3));
    acc = in_valid && (occ != 2);
    drn = out_ready && (occ != 0);
    if (drn) begin
      if (q4.size() == 0) check("q4_nonempty", 32'(0), 32'(1));
      else check("out_data4", 32'(out_data4), 32'(q4.pop_front()));
      if (q3.size() == 0) check("q3_nonempty", 32'(0), 32'(1));
      else check("out_data3", 32'(out_data3), 32'(q3.pop_front()));
    end
    if (acc) begin
      e4 = hold ? last4 : src[sel];
      if (hold) e3 = last3;
      else if (sel == 2'd3) begin
        e3   = 8'h00;
        err3 = 1'b1;
      end else e3 = src[sel];
      q4.push_back(e4);
      q3.push_back(e3);
      last4 = e4;
      last3 = e3;
    end
    occ = occ + int'(acc) - int'(drn);
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid4), 32'(0));
    check("rst_out_data",  32'(out_data4),  32'(0));
    check("rst_in_ready",  32'(in_ready4),  32'(1));
    check("rst_sel_err3",  32'(sel_err3),   32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hold      = 1'b0;
    sel       = 2'd0;
    for (int k = 0; k < 4; k++) src[k] = 8'h00;
    model_reset();
    #12;
    check("init_out_valid", 32'(out_valid4), 32'(0));
    check("init_in_ready",  32'(in_ready4),  32'(1));
    check("init_out_data",  32'(out_data4),  32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic select.
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    out_ready = 1'b1;
    sel = 2'd2; in_valid = 1'b1; cycle();
    in_valid = 1'b0; cycle(); cycle();

    // Copy mode: hold ignores sel (sel=3 would be out of range on dut3).
    sel = 2'd0; in_valid = 1'b1; cycle();
    sel = 2'd3; hold = 1'b1; cycle();
    hold = 1'b0; in_valid = 1'b0; cycle(); cycle();

    // Backpressure and skid.
    out_ready = 1'b0;
    sel = 2'd0; src[0] = 8'hA1; in_valid = 1'b1; cycle();
    src[0] = 8'hB2; cycle();
    src[0] = 8'hC3; cycle();
    in_valid = 1'b0; cycle();
    out_ready = 1'b1; cycle(); cycle(); cycle(); cycle();

    // Out-of-range select, then ten more transfers with sticky flag.
    src[0] = 8'h11;
    sel = 2'd3; in_valid = 1'b1; cycle();
    for (int i = 0; i < 10; i++) begin
      sel = 2'(i % 3);
      cycle();
    end
    in_valid = 1'b0; cycle(); cycle();

    // Reset with two entries held.
    out_ready = 1'b0;
    sel = 2'd0; src[0] = 8'hA1; in_valid = 1'b1; cycle();
    src[0] = 8'hB2; cycle();
    in_valid = 1'b0; cycle();
    async_reset();
    out_ready = 1'b1; hold = 1'b1; in_valid = 1'b1; cycle();
    hold = 1'b0; in_valid = 1'b0; cycle(); cycle();

    // Streaming at full rate.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) src[k] = 8'($urandom);
      sel = 2'(i % 4);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8 && occ != 0; i++) cycle();
    cycle();
    check("q4_empty", 32'(q4.size()), 32'(0));
    check("q3_empty", 32'(q3.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_copy_mux_pipe
